epu_job_loader: RTL and testbench

//  Host-side initiator for the signature-verify engine: assembles one verify job from a 32-bit word stream
//  (sig, key, rhash), issues it on the engine's valid/ready/result interface, waits for completion and

---
 rtl/epu_job_loader_if.sv | 28 ++
 rtl/epu_job_loader.sv | 166 ++++++++++++++++
 tb/tb_epu_job_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/epu_job_loader_if.sv
// rtl/epu_job_loader_if.sv - job-word stream, engine operand/handshake and result stream bundle
interface epu_job_loader_if;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [511:0] epu_sig;
  logic [255:0] epu_key;
  logic [255:0] epu_rhash;
  logic         epu_valid;
  logic         epu_ready;
  logic         epu_result;
  logic         r_valid;
  logic         r_ready;
  logic         r_pass;
  logic [1:0]   r_err;
  logic         busy;

  modport master (
    input  s_data, s_valid, s_last, epu_ready, epu_result, r_ready,
    output s_ready, epu_sig, epu_key, epu_rhash, epu_valid, r_valid, r_pass, r_err, busy
  );

  modport slave (
    output s_data, s_valid, s_last, epu_ready, epu_result, r_ready,
    input  s_ready, epu_sig, epu_key, epu_rhash, epu_valid, r_valid, r_pass, r_err, busy
  );
endinterface

// File: rtl/epu_job_loader.sv
// rtl/epu_job_loader.sv - assembles a 32-word verify job, issues it to the engine, reports pass/err
// Optional completion timeout enabled by defining EPU_JOB_TIMEOUT_EN.
module epu_job_loader #(
  parameter int HOLDOFF_CYCLES = 16
`ifdef EPU_JOB_TIMEOUT_EN
  , parameter int TMO_W = 24
`endif
) (
  input  logic               axiclk,
  input  logic               resetn,
  epu_job_loader_if.master   bus
);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 2);

  typedef enum logic [2:0] {
    S_HOLDOFF, S_LOAD, S_DRAIN, S_ISSUE, S_WAIT_DROP, S_WAIT_DONE, S_REPORT, S_RECOVER
  } state_t;

  state_t         r_state;
  logic [HW-1:0]  r_hold;
  logic [4:0]     r_k;
  logic           r_s_ready;
  logic [511:0]   r_sig;
  logic [255:0]   r_key;
  logic [255:0]   r_rhash;
  logic           r_epu_valid;
  logic           r_r_valid;
  logic           r_pass;
  logic [1:0]     r_err;
  logic           r_busy;
  logic           w_xfer;

`ifdef EPU_JOB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - 1'b1;
  logic [TMO_W-1:0] r_tmo;
  logic             r_tmo_hit;
`endif

  assign w_xfer = bus.s_valid & r_s_ready;

  always_ff @(posedge axiclk) begin
    if (!resetn) begin
      r_state     <= S_HOLDOFF;
      r_hold      <= HW'(HOLDOFF_CYCLES);
      r_k         <= 5'd0;
      r_s_ready   <= 1'b0;
      r_sig       <= '0;
      r_key       <= '0;
      r_rhash     <= '0;
      r_epu_valid <= 1'b0;
      r_r_valid   <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= 2'b00;
      r_busy      <= 1'b0;
`ifdef EPU_JOB_TIMEOUT_EN
      r_tmo       <= '0;
      r_tmo_hit   <= 1'b0;
`endif
    end else begin
      r_epu_valid <= 1'b0;
      case (r_state)
        S_HOLDOFF: begin
          r_busy <= 1'b1;
          if (r_hold <= HW'(1)) begin
            r_state   <= S_LOAD;
            r_k       <= 5'd0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end
        S_LOAD: if (w_xfer) begin
          if (!r_k[4])      r_sig[{r_k[3:0], 5'b0} +: 32]   <= bus.s_data;
          else if (!r_k[3]) r_key[{r_k[2:0], 5'b0} +: 32]   <= bus.s_data;
          else              r_rhash[{r_k[2:0], 5'b0} +: 32] <= bus.s_data;
          r_k    <= r_k + 5'd1;
          r_busy <= 1'b1;
          if (r_k == 5'd31) begin
            if (bus.s_last) begin
              r_state   <= S_ISSUE;
              r_s_ready <= 1'b0;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (bus.s_last) begin
            r_state   <= S_REPORT;
            r_s_ready <= 1'b0;
            r_r_valid <= 1'b1;
            r_pass    <= 1'b0;
            r_err     <= 2'b01;
          end
        end
        S_DRAIN: if (w_xfer && bus.s_last) begin
          r_state   <= S_REPORT;
          r_s_ready <= 1'b0;
          r_r_valid <= 1'b1;
          r_pass    <= 1'b0;
          r_err     <= 2'b01;
        end
        S_ISSUE: if (bus.epu_ready) begin
          r_epu_valid <= 1'b1;
          r_state     <= S_WAIT_DROP;
`ifdef EPU_JOB_TIMEOUT_EN
          r_tmo       <= '0;
`endif
        end
        // engine still shows the previous ready level here, so it is not trusted
        S_WAIT_DROP: r_state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (bus.epu_ready) begin
            r_state   <= S_REPORT;
            r_r_valid <= 1'b1;
            r_pass    <= bus.epu_result;
            r_err     <= 2'b00;
          end
`ifdef EPU_JOB_TIMEOUT_EN
          else if (r_tmo == TMO_LAST) begin
            r_tmo     <= r_tmo + 1'b1;
            r_state   <= S_REPORT;
            r_r_valid <= 1'b1;
            r_pass    <= 1'b0;
            r_err     <= 2'b10;
            r_tmo_hit <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        S_REPORT: if (bus.r_ready) begin
          r_r_valid <= 1'b0;
`ifdef EPU_JOB_TIMEOUT_EN
          if (r_tmo_hit) begin
            r_state   <= S_RECOVER;
            r_tmo_hit <= 1'b0;
          end else
`endif
          begin
            r_state   <= S_LOAD;
            r_k       <= 5'd0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        // the timed-out job's late result surfaces here and is dropped
        S_RECOVER: if (bus.epu_ready) begin
          r_state   <= S_LOAD;
          r_k       <= 5'd0;
          r_s_ready <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: r_state <= S_HOLDOFF;
      endcase
    end
  end

  assign bus.s_ready   = r_s_ready;
  assign bus.epu_sig   = r_sig;
  assign bus.epu_key   = r_key;
  assign bus.epu_rhash = r_rhash;
  assign bus.epu_valid = r_epu_valid;
  assign bus.r_valid   = r_r_valid;
  assign bus.r_pass    = r_pass;
  assign bus.r_err     = r_err;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_epu_job_loader.sv
// tb/tb_epu_job_loader.sv - directed bench for epu_job_loader with a simple engine model
module tb_epu_job_loader;
  logic axiclk = 1'b0;
  logic resetn = 1'b0;
  always #5 axiclk = ~axiclk;

  epu_job_loader_if bus();

`ifdef EPU_JOB_TIMEOUT_EN
  epu_job_loader #(.HOLDOFF_CYCLES(16), .TMO_W(4)) dut (.axiclk(axiclk), .resetn(resetn), .bus(bus));
`else
  epu_job_loader #(.HOLDOFF_CYCLES(16)) dut (.axiclk(axiclk), .resetn(resetn), .bus(bus));
`endif

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0;
  int eng_cnt = 0;
  int eng_delay = 50;
  bit eng_never = 1'b0;

  // engine: idle-ready, drops ready on issue, returns ready eng_delay cycles later
  always @(negedge axiclk) begin
    if (!resetn) begin
      bus.epu_ready = 1'b1;
      eng_cnt = 0;
    end else if (bus.epu_valid === 1'b1) begin
      n_valid++;
      eng_cnt = eng_delay;
      bus.epu_ready = 1'b0;
    end else if (!bus.epu_ready && !eng_never && eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) bus.epu_ready = 1'b1;
    end
  end

  task automatic send_words(input int first, input int count, input bit last_final);
    bit took;
    int g;
    for (int i = 0; i < count; i++) begin
      bus.s_data  = 32'(first + i);
      bus.s_valid = 1'b1;
      bus.s_last  = last_final && (i == count - 1);
      g = 0;
      do begin
        took = (bus.s_ready === 1'b1);
        @(negedge axiclk);
        g++;
      end while (!took && g < 300);
      if (!took) begin
        vectors++; miscompares++;
        $display("FAIL word_accept: word %0d not accepted within 300 cycles", first + i);
        break;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_rv(output bit ok);
    int g = 0;
    while (bus.r_valid !== 1'b1 && g < 1000) begin
      @(negedge axiclk);
      g++;
    end
    ok = (bus.r_valid === 1'b1);
  endtask

  task automatic ack;
    bus.r_ready = 1'b1;
    @(negedge axiclk);
    bus.r_ready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge axiclk);
    vectors++;
    if ({bus.s_ready, bus.epu_valid, bus.r_valid, bus.r_pass, bus.r_err, bus.busy} !== 7'd0 ||
        bus.epu_sig !== '0 || bus.epu_key !== '0 || bus.epu_rhash !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ctl=%b required 0000000", {bus.s_ready, bus.epu_valid, bus.r_valid,
               bus.r_pass, bus.r_err, bus.busy});
    end
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (bus.s_ready !== 1'b0 || bus.epu_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL holdoff_cycle_%0d: s_ready=%b epu_valid=%b required 0 0", i, bus.s_ready, bus.epu_valid);
      end
      @(negedge axiclk);
    end
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL holdoff_end: s_ready=%b busy=%b required 1 0", bus.s_ready, bus.busy);
    end
  endtask

  task automatic test_pass_job;
    bit ok;
    int base = n_valid;
    bus.epu_result = 1'b1;
    send_words(0, 32, 1'b1);
    vectors++;
    if (bus.epu_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL issue_early: epu_valid=%b required 0", bus.epu_valid);
    end
    @(negedge axiclk);
    vectors++;
    if (bus.epu_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_latency: epu_valid=%b required 1", bus.epu_valid);
    end
    wait_rv(ok);
    vectors++;
    if (!ok || bus.r_pass !== 1'b1 || bus.r_err !== 2'b00) begin
      miscompares++;
      $display("FAIL pass_result: r_valid=%b r_pass=%b r_err=%b required 1 1 00", bus.r_valid, bus.r_pass, bus.r_err);
    end
    vectors++;
    if (bus.epu_sig[31:0] !== 32'h0 || bus.epu_sig[511:480] !== 32'hF ||
        bus.epu_key[31:0] !== 32'h10 || bus.epu_rhash[255:224] !== 32'h1F) begin
      miscompares++;
      $display("FAIL operands: sig0=%h sig15=%h key0=%h rh7=%h required 0 f 10 1f", bus.epu_sig[31:0],
               bus.epu_sig[511:480], bus.epu_key[31:0], bus.epu_rhash[255:224]);
    end
    vectors++;
    if (n_valid != base + 1) begin
      miscompares++;
      $display("FAIL pass_pulses: epu_valid pulses=%0d required %0d", n_valid - base, 1);
    end
    ack;
    vectors++;
    if (bus.r_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL pass_ack: r_valid=%b s_ready=%b busy=%b required 0 1 0", bus.r_valid, bus.s_ready, bus.busy);
    end
  endtask

  task automatic test_hold_result;
    bit ok;
    bus.epu_result = 1'b0;
    send_words(0, 32, 1'b1);
    wait_rv(ok);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (bus.r_valid !== 1'b1 || bus.r_pass !== 1'b0 || bus.r_err !== 2'b00) begin
        miscompares++;
        $display("FAIL hold_cycle_%0d: r_valid=%b r_pass=%b r_err=%b required 1 0 00", i, bus.r_valid,
                 bus.r_pass, bus.r_err);
      end
      @(negedge axiclk);
    end
    ack;
    vectors++;
    if (bus.r_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_ack: r_valid=%b required 0", bus.r_valid);
    end
  endtask

  task automatic test_short_frame;
    bit ok;
    int base = n_valid;
    send_words(0, 6, 1'b1);
    wait_rv(ok);
    vectors++;
    if (!ok || bus.r_pass !== 1'b0 || bus.r_err !== 2'b01) begin
      miscompares++;
      $display("FAIL short_frame: r_valid=%b r_pass=%b r_err=%b required 1 0 01", bus.r_valid, bus.r_pass, bus.r_err);
    end
    ack;
    vectors++;
    if (n_valid != base) begin
      miscompares++;
      $display("FAIL short_no_issue: epu_valid pulses=%0d required 0", n_valid - base);
    end
    bus.epu_result = 1'b1;
    send_words(0, 32, 1'b1);
    wait_rv(ok);
    vectors++;
    if (!ok || bus.r_pass !== 1'b1 || bus.r_err !== 2'b00 || n_valid != base + 1) begin
      miscompares++;
      $display("FAIL after_short: r_pass=%b r_err=%b pulses=%0d required 1 00 1", bus.r_pass, bus.r_err, n_valid - base);
    end
    ack;
  endtask

  task automatic test_drain;
    bit ok;
    int base = n_valid;
    send_words(0, 32, 1'b0);
    vectors++;
    if (bus.r_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_entry: r_valid=%b s_ready=%b busy=%b required 0 1 1", bus.r_valid, bus.s_ready, bus.busy);
    end
    send_words(32, 8, 1'b1);
    wait_rv(ok);
    vectors++;
    if (!ok || bus.r_pass !== 1'b0 || bus.r_err !== 2'b01 || n_valid != base) begin
      miscompares++;
      $display("FAIL drain_result: r_pass=%b r_err=%b pulses=%0d required 0 01 0", bus.r_pass, bus.r_err, n_valid - base);
    end
    ack;
  endtask

  task automatic test_issue_hold;
    bit ok;
    int base = n_valid;
    eng_never = 1'b1;
    bus.epu_ready = 1'b0;
    send_words(100, 32, 1'b1);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.epu_valid !== 1'b0 || bus.epu_sig[31:0] !== 32'd100 || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL issue_hold_%0d: epu_valid=%b sig0=%h busy=%b required 0 64 1", i, bus.epu_valid,
                 bus.epu_sig[31:0], bus.busy);
      end
      @(negedge axiclk);
    end
    bus.epu_result = 1'b1;
    eng_never = 1'b0;
    bus.epu_ready = 1'b1;
    @(negedge axiclk);
    vectors++;
    if (bus.epu_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_release: epu_valid=%b required 1", bus.epu_valid);
    end
    wait_rv(ok);
    vectors++;
    if (!ok || bus.r_pass !== 1'b1 || n_valid != base + 1) begin
      miscompares++;
      $display("FAIL issue_hold_result: r_pass=%b pulses=%0d required 1 1", bus.r_pass, n_valid - base);
    end
    ack;
  endtask

  task automatic test_back_to_back;
    bit ok;
    send_words(0, 32, 1'b1);
    wait_rv(ok);
    bus.s_data  = 32'h0;
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b0;
    bus.r_ready = 1'b1;
    @(negedge axiclk);
    bus.r_ready = 1'b0;
    vectors++;
    if (!ok || bus.r_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ack: r_valid=%b s_ready=%b busy=%b required 0 1 0", bus.r_valid, bus.s_ready, bus.busy);
    end
    @(negedge axiclk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b required 1", bus.busy);
    end
    send_words(1, 31, 1'b1);
    wait_rv(ok);
    vectors++;
    if (!ok || bus.r_err !== 2'b00 || bus.epu_sig[63:32] !== 32'd1) begin
      miscompares++;
      $display("FAIL b2b_job: r_err=%b sig1=%h required 00 1", bus.r_err, bus.epu_sig[63:32]);
    end
    ack;
  endtask

  task automatic test_reset_mid_job;
    bit ok;
    int base = n_valid;
    send_words(7, 10, 1'b0);
    resetn = 1'b0;
    @(negedge axiclk);
    vectors++;
    if (bus.s_ready !== 1'b0 || bus.busy !== 1'b0 || bus.r_valid !== 1'b0 || bus.epu_sig !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: s_ready=%b busy=%b r_valid=%b sig0=%h required 0 0 0 0", bus.s_ready,
               bus.busy, bus.r_valid, bus.epu_sig[31:0]);
    end
    resetn = 1'b1;
    repeat (16) @(negedge axiclk);
    vectors++;
    if (bus.s_ready !== 1'b1 || n_valid != base) begin
      miscompares++;
      $display("FAIL mid_reset_resume: s_ready=%b pulses=%0d required 1 0", bus.s_ready, n_valid - base);
    end
    bus.epu_result = 1'b1;
    send_words(0, 32, 1'b1);
    wait_rv(ok);
    vectors++;
    if (!ok || bus.r_pass !== 1'b1 || n_valid != base + 1) begin
      miscompares++;
      $display("FAIL mid_reset_job: r_pass=%b pulses=%0d required 1 1", bus.r_pass, n_valid - base);
    end
    ack;
  endtask

`ifdef EPU_JOB_TIMEOUT_EN
  task automatic test_timeout;
    int g = 0;
    eng_never = 1'b1;
    bus.epu_result = 1'b1;
    send_words(0, 32, 1'b1);
    while (bus.epu_valid !== 1'b1 && g < 10) begin @(negedge axiclk); g++; end
    g = 0;
    while (bus.r_valid !== 1'b1 && g < 100) begin @(negedge axiclk); g++; end
    vectors++;
    if (g != 16 || bus.r_pass !== 1'b0 || bus.r_err !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout: cycles=%0d r_pass=%b r_err=%b required 16 0 10", g, bus.r_pass, bus.r_err);
    end
    ack;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.s_ready !== 1'b0 || bus.r_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL recover_%0d: s_ready=%b r_valid=%b required 0 0", i, bus.s_ready, bus.r_valid);
      end
      @(negedge axiclk);
    end
    eng_never = 1'b0;
    bus.epu_ready = 1'b1;
    repeat (2) @(negedge axiclk);
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.r_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL recover_exit: s_ready=%b r_valid=%b required 1 0", bus.s_ready, bus.r_valid);
    end
  endtask
`endif

  initial begin
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.r_ready = 1'b0;
    bus.epu_result = 1'b0;
    bus.epu_ready = 1'b1;
`ifdef EPU_JOB_TIMEOUT_EN
    eng_delay = 8;
`endif
    @(negedge axiclk);
    test_reset;
    test_pass_job;
    test_hold_result;
    test_short_frame;
    test_drain;
    test_issue_hold;
    test_back_to_back;
    test_reset_mid_job;
`ifdef EPU_JOB_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
